// File: rtl/fwd_select_stage_if.sv
// Bus bundle for fwd_select_stage: operand sources and pipeline control in,
// registered operand and status out.
interface fwd_select_stage_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NSRC  = 3
);
  localparam int unsigned SEL_W = $clog2(NSRC);

  logic                    In_Valid;
  logic [NSRC*WIDTH-1:0]   In_Data;
  logic [SEL_W-1:0]        Control;
  logic                    Stall;
  logic                    Flush;
  logic [WIDTH-1:0]        Output;
  logic                    Out_Valid;
  logic                    Sel_Err;
  logic [15:0]             Fwd_Count;

  // Upstream side: drives sources and control, observes the stage.
  modport master (
    output In_Valid, In_Data, Control, Stall, Flush,
    input  Output, Out_Valid, Sel_Err, Fwd_Count
  );

  // Stage side.
  modport slave (
    input  In_Valid, In_Data, Control, Stall, Flush,
    output Output, Out_Valid, Sel_Err, Fwd_Count
  );
endinterface

// File: rtl/fwd_select_stage.sv
// Operand-forwarding select stage: picks one of NSRC sources (0 = register
// file, 1..NSRC-1 = bypasses) and registers it with valid/stall/flush control.
// Out-of-range selects fall back to source 0 and set a sticky error flag.
// Optional feature macro: FWD_SELECT_COUNT_EN builds the saturating
// forwarding-event counter; otherwise Fwd_Count is tied to zero.
module fwd_select_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NSRC  = 3
) (
  input  logic                 Clk,
  input  logic                 Rst,
  fwd_select_stage_if.slave    bus
);
  localparam int unsigned SEL_W   = $clog2(NSRC);
  localparam int unsigned CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] sel_data_c;
  logic             sel_legal_c;
  logic             sel_bypass_c;
  logic             accept_c;

  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             sel_err_q, sel_err_d;

  // Source select: any select outside 0..NSRC-1 resolves to the register file.
  always_comb begin
    sel_data_c = bus.In_Data[WIDTH-1:0];
    for (int k = 1; k < int'(NSRC); k++) begin
      if (bus.Control == SEL_W'(k)) begin
        sel_data_c = bus.In_Data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Transfer qualifiers shared by the data path, error flag and counter.
  always_comb begin
    sel_legal_c  = (32'(bus.Control) < NSRC);
    sel_bypass_c = sel_legal_c && (bus.Control != '0);
    accept_c     = bus.In_Valid && !bus.Stall && !bus.Flush;
  end

  // Next-state for the stage register: flush beats stall beats normal update.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    sel_err_d   = sel_err_q;
    if (bus.Flush) begin
      out_d       = '0;
      out_valid_d = 1'b0;
    end else if (!bus.Stall) begin
      out_valid_d = bus.In_Valid;
      if (bus.In_Valid) begin
        out_d = sel_data_c;
      end
    end
    if (accept_c && !sel_legal_c) begin
      sel_err_d = 1'b1;
    end
  end

  // Stage register with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign bus.Output    = out_q;
  assign bus.Out_Valid = out_valid_q;
  assign bus.Sel_Err   = sel_err_q;

`ifdef FWD_SELECT_COUNT_EN
  logic [CNT_W-1:0] fwd_count_q, fwd_count_d;

  // Count accepted bypass selections, saturating at all-ones.
  always_comb begin
    fwd_count_d = fwd_count_q;
    if (accept_c && sel_bypass_c && (fwd_count_q != CNT_MAX)) begin
      fwd_count_d = fwd_count_q + CNT_W'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      fwd_count_q <= '0;
    end else begin
      fwd_count_q <= fwd_count_d;
    end
  end

  assign bus.Fwd_Count = fwd_count_q;
`else
  logic unused_bypass_c;

  // Bypass qualifier only feeds the counter; keep it referenced.
  always_comb unused_bypass_c = sel_bypass_c ^ CNT_MAX[0];

  assign bus.Fwd_Count = 16'h0000;
`endif

endmodule

// File: doc/fwd_select_stage.md
# fwd_select_stage

Parametrised operand-forwarding select stage for the pipelined datapath. It selects one of NSRC candidate operand sources: source 0 is the register-file read value, sources 1..NSRC-1 are bypass values from later stages. The selected value is registered into the next pipeline stage with valid, stall and flush control. Compared with a plain three-way mux, it adds:
- defined behaviour for out-of-range selects, with a sticky error flag;
- hold-on-stall and clear-on-flush;
- an optional saturating forwarding-event counter.

## Interface
Parameters:
- WIDTH, 32, operand width in bits
- NSRC, 3, number of candidate sources (2..16); source 0 = register file
- SEL_W, derived = $clog2(NSRC), select width (not overridden)

Ports (one clock; reset is synchronous and active-low):
- Clk  input  1  rising-edge clock
- Rst  input  1  synchronous active-low reset, sampled on rising Clk
- In_Valid  input  1  upstream operand valid this cycle
- In_Data  input  NSRC*WIDTH  packed sources; source k at In_Data[k*WIDTH +: WIDTH]
- Control  input  SEL_W  source select from the hazard/forwarding detector
- Stall  input  1  hold the stage register
- Flush  input  1  kill the stage contents
- Output  output  WIDTH  registered selected operand
- Out_Valid  output  1  Output holds a live operand
- Sel_Err  output  1  sticky: an out-of-range select was accepted
- Fwd_Count  output  16  saturating count of accepted bypass selections

## Operation
- Next-value select (combinational):
  - Control < NSRC: select source Control.
  - Control >= NSRC: select source 0. This case is possible only when NSRC is not a power of 2.
  - No latch inferred; every Control value drives a defined result.
- Accept condition: `accept = In_Valid & ~Stall & ~Flush`.
- Update priority at each rising Clk, highest first: Rst=0 > Flush > Stall > normal.
  - **Rst=0**: Output=0, Out_Valid=0, Sel_Err=0, Fwd_Count=0.
  - **Flush=1**: Output=0, Out_Valid=0. Sel_Err and Fwd_Count unchanged.
  - **Stall=1** (no Flush): Output, Out_Valid, Sel_Err and Fwd_Count all hold. Inputs are ignored.
  - **Normal, In_Valid=1**: Output = selected value, Out_Valid=1.
  - **Normal, In_Valid=0**: Out_Valid=0, Output holds its previous value.
- Sel_Err: set on an accepted transfer with Control >= NSRC. Cleared only by reset.
- Fwd_Count:
  - Increments by 1 on an accepted transfer with 0 < Control < NSRC.
  - Saturates at 0xFFFF; no wrap.
  - Source-0 selections and illegal selects do not count.

## Timing
- Latency: 1 cycle from accepted inputs to Output/Out_Valid.
- Throughput: 1 operand per cycle when Stall=0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Stall asserted for N cycles holds the outputs for N cycles. The first accepted transfer after deassertion updates on the following edge.
- Flush and Stall on the same edge: Flush wins, so Out_Valid=0 and Output=0.
- Reset mid-stream: the in-flight operand is discarded. Out_Valid=0 on the edge after Rst is sampled low.
- Illegal select and saturation can coincide: Sel_Err sets, the count does not change.

## Configuration
- Macro `FWD_SELECT_COUNT_EN`:
  - **Defined**: Fwd_Count logic is built as described above.
  - **Undefined**: the counter register is omitted and Fwd_Count is tied to 16'h0000. All other behaviour is identical.

## Test plan
All scenarios use WIDTH=32, NSRC=3, with sources 0x11111111, 0x22222222, 0x33333333.
- **Reset**: hold Rst=0 for 2 edges with random inputs -> Output=0, Out_Valid=0, Sel_Err=0, Fwd_Count=0.
- **Select**: In_Valid=1, Control=2 -> next edge Output=0x33333333, Out_Valid=1, Fwd_Count=1. Then Control=0 -> Output=0x11111111, Fwd_Count stays 1.
- **Stall**: after Output=0x33333333, Stall=1 for 3 cycles with Control=1 -> Output stays 0x33333333, Fwd_Count unchanged. Stall=0 -> next edge Output=0x22222222.
- **Flush/stall conflict**: Flush=1 and Stall=1 on the same edge -> Out_Valid=0, Output=0x00000000.
- **Illegal select**: Control=3, In_Valid=1 -> Output=0x11111111, Sel_Err=1 and it persists after legal selects. Fwd_Count unchanged.
- **Saturation**: 65540 accepted Control=1 transfers -> Fwd_Count=0xFFFF. With FWD_SELECT_COUNT_EN undefined, Fwd_Count=0 throughout.
